// File: rtl/toggle_event_decoder_if.sv
// toggle_event_decoder_if
//   Bundles the toggle line, the consumer handshake and the status outputs
//   of toggle_event_decoder.
//   master : event source / consumer side (drives T_in, Ev_ready)
//   slave  : decoder side (drives Ev_pulse, Ev_valid, Pending, Count,
//            Overflow, Level)
interface toggle_event_decoder_if #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 4
);
    logic              T_in;
    logic              Ev_ready;
    logic              Ev_pulse;
    logic              Ev_valid;
    logic [PEND_W-1:0] Pending;
    logic [CNT_W-1:0]  Count;
    logic              Overflow;
    logic              Level;

    modport master (
        output T_in, Ev_ready,
        input  Ev_pulse, Ev_valid, Pending, Count, Overflow, Level
    );

    modport slave (
        input  T_in, Ev_ready,
        output Ev_pulse, Ev_valid, Pending, Count, Overflow, Level
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
//   Recovers events from a remote toggle flip-flop. T_in is synchronised,
//   each level change becomes a one-cycle Ev_pulse, and events are queued as
//   a pending count drained through a valid/ready handshake. Also keeps a
//   wrapping event count and a sticky overflow flag.
// Ports
//   Clk  : clock, rising edge
//   SR   : asynchronous active-high reset
//   bus  : slave modport of toggle_event_decoder_if
//          in  T_in, Ev_ready
//          out Ev_pulse, Ev_valid, Pending, Count, Overflow, Level
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic                    Clk,
    input  logic                    SR,
    toggle_event_decoder_if.slave   bus
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } pend_state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_valid;
    logic                   r_ovf;
    logic [PEND_W-1:0]      r_pend;
    logic [CNT_W-1:0]       r_count;
    pend_state_t            r_state;

    logic                   w_edge;
    logic                   w_accept;
    logic                   w_drop;
    logic [PEND_W-1:0]      w_pend_nxt;

    // Either polarity of change on the synchronised line is one event.
    assign w_edge   = r_sync[SYNC_STAGES-1] ^ r_level;
    // Uses the registered valid, so Ev_ready never reaches Ev_valid combinationally.
    assign w_accept = r_valid & bus.Ev_ready;

    always_comb begin
        w_pend_nxt = r_pend;
        w_drop     = 1'b0;
        if (w_edge && !w_accept) begin
            if (r_state == ST_FULL)
                w_drop = 1'b1;          // no room: event is lost
            else
                w_pend_nxt = r_pend + PEND_W'(1);
        end else if (w_accept && !w_edge) begin
            w_pend_nxt = r_pend - PEND_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge SR) begin
        if (SR) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_pend  <= '0;
            r_count <= '0;
            r_state <= ST_EMPTY;
        end else begin
            // Only r_sync[0] samples the asynchronous input.
            r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.T_in};
            r_level <= r_sync[SYNC_STAGES-1];
            r_pulse <= w_edge;
            if (w_edge)
                r_count <= r_count + CNT_W'(1);
            if (w_drop)
                r_ovf <= 1'b1;
            r_pend  <= w_pend_nxt;
            r_valid <= (w_pend_nxt != '0);
            if (w_pend_nxt == '0)
                r_state <= ST_EMPTY;
            else if (w_pend_nxt == PEND_MAX)
                r_state <= ST_FULL;
            else
                r_state <= ST_HOLD;
        end
    end

    assign bus.Ev_pulse = r_pulse;
    assign bus.Ev_valid = r_valid;
    assign bus.Pending  = r_pend;
    assign bus.Count    = r_count;
    assign bus.Overflow = r_ovf;
    assign bus.Level    = r_level;

endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receive-side decoder for toggle-encoded event signalling. A remote T flip-flop flips its output once per event; this block synchronises that level into the local `Clk` domain, turns each detected level change back into a one-cycle pulse, and buffers pending events behind a valid/ready handshake for a slower consumer. It also keeps a running event count and a sticky overflow flag. It sits at the boundary between an event source driven by a toggle flip-flop and the local control logic.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `T_in`; legal range 2..4.
- `CNT_W`, default 8: width of the event counter `Count`.
- `PEND_W`, default 4: width of the pending-event counter; maximum pending is 2^PEND_W − 1.

- `Clk`  in  1: single clock; all state updates on its rising edge.
- `SR`  in  1: reset, asynchronous, active-high; clears all state immediately.
- `T_in`  in  1: toggle line from the remote T flip-flop, which resets to 0; may be asynchronous to `Clk`.
- `Ev_ready`  in  1: consumer accepts one pending event when high with `Ev_valid`.
- `Ev_pulse`  out  1: one-cycle pulse per detected toggle.
- `Ev_valid`  out  1: high while pending events exist.
- `Pending`  out  PEND_W: number of events detected and not yet accepted.
- `Count`  out  CNT_W: total detected toggles, modulo 2^CNT_W.
- `Overflow`  out  1: sticky; an event was detected while `Pending` was at maximum and was not accepted in the same cycle.
- `Level`  out  1: synchronised, registered copy of `T_in`.

## Operation
- Synchroniser: `T_in` passes through SYNC_STAGES flops, `sync[0]` to `sync[SYNC_STAGES-1]`. `Level` is a further register fed by the last stage.
- Edge detection: combinational `edge = sync[SYNC_STAGES-1] ^ Level`. Rising and falling transitions of `T_in` both count as one event each.
- `Ev_pulse` is registered from `edge`.
- Pending counter, updated every cycle:
  - edge and no accept: +1.
  - accept and no edge: −1.
  - edge and accept together: unchanged.
  - neither: unchanged.
- Accept means `Ev_valid && Ev_ready`. `Ev_ready` while `Ev_valid` = 0 has no effect; `Pending` never goes below 0.
- `Ev_valid` is asserted exactly when `Pending` != 0. It is derived from the registered counter, with no combinational path from `Ev_ready`.
- Pending states:
  - EMPTY (`Pending` = 0): an edge moves to HOLD.
  - HOLD (0 < `Pending` < max): edges and accepts move between HOLD, EMPTY and FULL.
  - FULL (`Pending` = max): an edge with no accept keeps `Pending` at max and sets `Overflow`. An edge with an accept keeps `Pending` at max and does not set `Overflow`.
- `Count` increments on every edge, including dropped events, and wraps from 2^CNT_W − 1 to 0.
- `Overflow` clears only on `SR`.
- Reset values while `SR` = 1: all `sync` flops 0, `Level` 0, `Ev_pulse` 0, `Ev_valid` 0, `Pending` 0, `Count` 0, `Overflow` 0. Asserting `SR` mid-operation discards pending events immediately.
- After `SR` deasserts: if `T_in` is already 1, one event is detected SYNC_STAGES + 1 edges later. This matches an encoder that toggled before reset was released.

## Timing
- Latency: suppose a `T_in` transition is first captured by `sync[0]` at rising edge k. At edge k + SYNC_STAGES the following update together: `Ev_pulse` = 1 for one cycle, `Pending` +1, `Count` +1, and `Level` takes the new value.
- Accept: `Ev_valid && Ev_ready` sampled at edge j decrements `Pending` at edge j. `Ev_valid` drops at edge j only if `Pending` was 1 and no edge was detected in that cycle.
- Input rule: `T_in` must stay stable for at least 2 `Clk` periods between toggles. Faster toggling may merge transitions; an even number of merged toggles produces no event. No error is flagged for this.
- Metastability: only `sync[0]` samples `T_in`; no other logic reads `T_in`.

## Test plan
- Reset and idle: hold `SR` = 1 for 3 cycles with `T_in` = 0, then release. All outputs stay 0 for 20 cycles.
- Single toggle, SYNC_STAGES = 2: raise `T_in` just before edge k. At edge k+2: `Ev_pulse` high for exactly one cycle, `Pending` = 1, `Ev_valid` = 1, `Count` = 1, `Level` = 1. Assert `Ev_ready` one cycle: `Pending` = 0, `Ev_valid` = 0.
- Burst with no consumer, PEND_W = 4: 17 toggles spaced 3 cycles apart with `Ev_ready` = 0.
  - After the 15th: `Pending` = 15, `Overflow` = 0.
  - After the 16th: `Overflow` = 1, `Pending` = 15.
  - After the 17th: `Count` = 17.
- Simultaneous edge and accept: `Pending` = 3 with an edge arriving while `Ev_ready` = 1. `Pending` stays 3 and `Ev_pulse` = 1. Repeat at `Pending` = 15: `Overflow` stays 0.
- Count wrap, CNT_W = 8: 257 toggles with `Ev_ready` held at 1. `Count` = 1, `Pending` = 0, `Overflow` = 0.
- Reset mid-operation: with `Pending` = 5 and `T_in` = 1, assert `SR` asynchronously between clock edges. All outputs are 0 immediately. After release, exactly one event is detected 3 edges later: `Count` = 1.
